// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: register/data widths,
// the writeback request struct and the starvation FSM states.
package wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLOCKED,
    ST_FORCE
  } starve_state_e;

endpackage

// File: rtl/wb_arbiter_pending_sb.sv
// Pending-write scoreboard: one bit per architectural register, set on MDU
// issue, cleared on MDU writeback; a same-cycle set beats the clear.
module wb_pending_sb
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]  pending_mask
);

  logic [NUM_REGS-1:0] mask_d, mask_q;

  // NOTE: always_comb starts from a full default so no path leaves mask_d
  // unassigned; that is what keeps this from inferring a latch.
  always_comb begin
    mask_d = mask_q;
    if (clr_en) mask_d[clr_idx] = 1'b0;
    // x0 is hardwired to zero and never awaits a write.
    if (set_en && set_idx != '0) mask_d[set_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign pending_mask = mask_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter merging pipeline writeback and MDU results.
// Optional WB_STATS_EN adds stat_drains/stat_forced wrapping event counters.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  output logic                 pipe_stall,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [REG_IDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]      mdu_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]  pending_mask,
`ifdef WB_STATS_EN
  output logic [31:0]          stat_drains,
  output logic [31:0]          stat_forced,
`endif
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wdata
);

  starve_state_e        state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 buf_valid_d, buf_valid_q;
  logic [REG_IDX_W-1:0] buf_rd_d, buf_rd_q;
  logic [XLEN-1:0]      buf_data_d, buf_data_q;
  wb_req_t              rf_req;
  logic                 drain, accept, blocked;

  assign pipe_stall = (state_q == ST_FORCE);

  always_comb begin
    drain  = buf_valid_q & (pipe_stall | ~pipe_we);
    rf_req = '0;
    if (drain)        rf_req = '{we: 1'b1, rd: buf_rd_q, data: buf_data_q};
    else if (pipe_we) rf_req = '{we: 1'b1, rd: pipe_rd, data: pipe_data};

    // A draining entry frees the slot in time for a same-cycle refill.
    mdu_ready = ~buf_valid_q | drain;
    accept    = mdu_valid & mdu_ready;

    buf_valid_d = buf_valid_q & ~drain;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (accept) begin
      buf_valid_d = (mdu_rd != '0);
      buf_rd_d    = mdu_rd;
      buf_data_d  = mdu_data;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    blocked = buf_valid_q & pipe_we & ~pipe_stall;
    if (blocked) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(STARVE_LIMIT - 1)) ? ST_FORCE : ST_BLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // NOTE: the buffer payload carries no reset; it is only ever observed
  // while buf_valid_q is set, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

  wb_pending_sb u_pending_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en       (issue_valid),
    .set_idx      (issue_rd),
    .clr_en       (drain),
    .clr_idx      (buf_rd_q),
    .pending_mask (pending_mask)
  );

  assign rf_we    = rf_req.we;
  assign rf_rd    = rf_req.rd;
  assign rf_wdata = rf_req.data;

`ifdef WB_STATS_EN
  logic [31:0] stat_drains_d, stat_drains_q;
  logic [31:0] stat_forced_d, stat_forced_q;

  always_comb begin
    stat_drains_d = stat_drains_q + (drain ? 32'd1 : 32'd0);
    stat_forced_d = stat_forced_q + (pipe_stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_drains_q <= '0;
      stat_forced_q <= '0;
    end else begin
      stat_drains_q <= stat_drains_d;
      stat_forced_q <= stat_forced_d;
    end
  end

  assign stat_drains = stat_drains_q;
  assign stat_forced = stat_forced_q;
`endif

endmodule
